// File: rtl/mem_pkg.sv
// Shared types and defaults for the MAR/MDR memory interface.
// Optional parity storage is enabled by defining MEM_PARITY_EN.
package mem_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 9;
    localparam int DEF_DEPTH       = 512;
    localparam int DEF_WAIT_STATES = 1;

    // Width of the wait-state down-counter; caps WAIT_STATES at 15.
    localparam int WS_W = 4;

`ifdef MEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with synchronous write and registered read.
// Each word carries an extra parity bit when MEM_PARITY_EN is defined.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clock,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [DATA_W+PAR_W-1:0]   wdata,
    input  logic                      re,
    input  logic [ADDR_W-1:0]         raddr,
    output logic [DATA_W+PAR_W-1:0]   rdata
);

    logic [DATA_W+PAR_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/memory_interface.sv
// MAR/MDR front end to a block-RAM array with programmable wait states.
// Defining MEM_PARITY_EN adds per-word even parity and the parity_err output.
module memory_interface
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] BusMuxInMDR,
    output logic              busy,
    output logic              done,
    output logic              addr_err
`ifdef MEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int WORD_W = DATA_W + PAR_W;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [WS_W-1:0]   cnt_reg, cnt_next;
    logic [ADDR_W-1:0] mar_reg, mar_next;
    logic [DATA_W-1:0] mdr_reg, mdr_next;
    logic              op_write_reg, op_write_next;
    logic              done_reg, addr_err_reg;
    logic              mar_in_range, next_in_range, array_we;
    logic [WORD_W-1:0] wr_word, rd_word;

    assign mar_in_range  = {1'b0, mar_reg}  < DEPTH_V;
    assign next_in_range = {1'b0, mar_next} < DEPTH_V;
    assign array_we      = (state_reg == ACCESS) && op_write_reg && mar_in_range && clear;

`ifdef MEM_PARITY_EN
    logic parity_err_reg;
    assign wr_word    = {^mdr_reg, mdr_reg};
    assign parity_err = parity_err_reg;
`else
    assign wr_word = mdr_reg;
`endif

    // Read port follows mar_next so the word is already registered when ACCESS begins.
    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock (clock),
        .we    (array_we),
        .waddr (mar_reg),
        .wdata (wr_word),
        .re    (next_in_range),
        .raddr (mar_next),
        .rdata (rd_word)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mar_next      = mar_reg;
        mdr_next      = mdr_reg;
        op_write_next = op_write_reg;
        case (state_reg)
            IDLE: begin
                if (MARin) mar_next = BusMuxOut[ADDR_W-1:0];
                if (MDRin) mdr_next = BusMuxOut;
                if (read || write) begin
                    op_write_next = write;
                    if (WAIT_STATES == 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WS_W'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == WS_W'(1)) state_next = ACCESS;
            end
            ACCESS: begin
                state_next = IDLE;
                if (!op_write_reg) mdr_next = mar_in_range ? rd_word[DATA_W-1:0] : '0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            mar_reg        <= '0;
            mdr_reg        <= '0;
            op_write_reg   <= 1'b0;
            done_reg       <= 1'b0;
            addr_err_reg   <= 1'b0;
`ifdef MEM_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            mar_reg        <= mar_next;
            mdr_reg        <= mdr_next;
            op_write_reg   <= op_write_next;
            done_reg       <= (state_reg == ACCESS);
            addr_err_reg   <= (state_reg == ACCESS) && !mar_in_range;
`ifdef MEM_PARITY_EN
            parity_err_reg <= (state_reg == ACCESS) && !op_write_reg && mar_in_range && (^rd_word);
`endif
        end
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign addr_err    = addr_err_reg;
    assign BusMuxInMDR = mdr_reg;

endmodule

// File: tb/tb_memory_interface.sv
// Scoreboard bench for memory_interface: dut0 uses defaults, dut1 has WAIT_STATES=0, DEPTH=256.
// The MEM_PARITY_EN build also exercises parity_err on dut0.
module tb_memory_interface;

    typedef struct {
        int          due;
        logic        aerr;
        logic        perr;
        bit          chk_mdr;
        logic [31:0] mdr;
        bit          is_write;
    } exp_t;

    logic        clock = 1'b0;
    logic        clear_v [2];
    logic [31:0] bus_v   [2];
    logic        marin_v [2];
    logic        mdrin_v [2];
    logic        rd_v    [2];
    logic        wr_v    [2];
    logic [31:0] mdr_o   [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic        aerr_o  [2];
    logic        perr_o  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    // Reference model: architectural MAR/MDR and array contents with "known" flags.
    logic [31:0] ref_mem   [2][512];
    bit          ref_known [2][512];
    logic [8:0]  ref_mar   [2];
    logic [31:0] ref_mdr   [2];
    bit          ref_mdr_known [2];
    bit          force_perr [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    memory_interface #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(1)) u_dut0 (
        .clock(clock), .clear(clear_v[0]), .BusMuxOut(bus_v[0]), .MARin(marin_v[0]),
        .MDRin(mdrin_v[0]), .read(rd_v[0]), .write(wr_v[0]), .BusMuxInMDR(mdr_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .addr_err(aerr_o[0])
`ifdef MEM_PARITY_EN
        , .parity_err(perr_o[0])
`endif
    );

    memory_interface #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(0)) u_dut1 (
        .clock(clock), .clear(clear_v[1]), .BusMuxOut(bus_v[1]), .MARin(marin_v[1]),
        .MDRin(mdrin_v[1]), .read(rd_v[1]), .write(wr_v[1]), .BusMuxInMDR(mdr_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .addr_err(aerr_o[1])
`ifdef MEM_PARITY_EN
        , .parity_err(perr_o[1])
`endif
    );

`ifndef MEM_PARITY_EN
    assign perr_o[0] = 1'b0;
    assign perr_o[1] = 1'b0;
`endif

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 512 : 256;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic exp_t qpop(input int k);
        exp_t e;
        if (k == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        return e;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle(input int k);
        marin_v[k] = 1'b0;
        mdrin_v[k] = 1'b0;
        rd_v[k]    = 1'b0;
        wr_v[k]    = 1'b0;
        bus_v[k]   = '0;
    endtask

    // One IDLE-cycle transaction; returns at the start of the done cycle (or next cycle).
    // junk: 0 quiet while busy, 1 random inputs while busy, 2 MDRin with all-ones while busy.
    task automatic do_op(input int k, input logic [31:0] b, input bit lm, input bit ld,
                         input bit r, input bit w, input int junk);
        exp_t e;
        int   n;
        bit   inr;
        bus_v[k]   = b;
        marin_v[k] = lm;
        mdrin_v[k] = ld;
        rd_v[k]    = r;
        wr_v[k]    = w;
        n = cyc;
        if (lm) ref_mar[k] = b[8:0];
        if (ld) begin
            ref_mdr[k]       = b;
            ref_mdr_known[k] = 1'b1;
        end
        if (r || w) begin
            inr        = int'(ref_mar[k]) < depth_of(k);
            e.due      = n + ws_of(k) + 2;
            e.aerr     = !inr;
            e.perr     = 1'b0;
            e.is_write = w;
            if (w) begin
                if (inr) begin
                    ref_mem[k][ref_mar[k]]   = ref_mdr[k];
                    ref_known[k][ref_mar[k]] = ref_mdr_known[k];
                end
            end else if (inr) begin
                ref_mdr[k]       = ref_mem[k][ref_mar[k]];
                ref_mdr_known[k] = ref_known[k][ref_mar[k]];
                e.perr           = force_perr[k];
                force_perr[k]    = 1'b0;
            end else begin
                ref_mdr[k]       = '0;
                ref_mdr_known[k] = 1'b1;
            end
            e.chk_mdr = ref_mdr_known[k];
            e.mdr     = ref_mdr[k];
            if (k == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            repeat (ws_of(k) + 1) begin
                tick();
                if (junk == 1) begin
                    bus_v[k]   = $urandom;
                    marin_v[k] = 1'($urandom);
                    mdrin_v[k] = 1'($urandom);
                    rd_v[k]    = 1'($urandom);
                    wr_v[k]    = 1'($urandom);
                end else if (junk == 2) begin
                    bus_v[k]   = 32'hFFFF_FFFF;
                    marin_v[k] = 1'b1;
                    mdrin_v[k] = 1'b1;
                    rd_v[k]    = 1'b0;
                    wr_v[k]    = 1'b1;
                end else begin
                    drive_idle(k);
                end
            end
        end
        tick();
        drive_idle(k);
    endtask

    // Start a write to addr and pull clear low one cycle later; the write must vanish.
    task automatic reset_mid(input int k, input logic [31:0] addr, input logic [31:0] data);
        do_op(k, data, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        bus_v[k]   = addr;
        marin_v[k] = 1'b1;
        wr_v[k]    = 1'b1;
        tick();
        drive_idle(k);
        clear_v[k] = 1'b0;
        @(negedge clock);
        chk("busy_before_reset", k, 32'(busy_o[k]), 32'd1);
        tick();
        clear_v[k] = 1'b1;
        @(negedge clock);
        chk("busy_after_reset", k, 32'(busy_o[k]), 32'd0);
        chk("done_after_reset", k, 32'(done_o[k]), 32'd0);
        chk("mdr_after_reset", k, mdr_o[k], 32'd0);
        tick();
        ref_mar[k]       = '0;
        ref_mdr[k]       = '0;
        ref_mdr_known[k] = 1'b1;
        $display("[TB] dut%0d reset abandoned write to %h", k, addr);
    endtask

    task automatic drive_seq(input int k);
        logic [31:0] b;
        bit lm, ld, r, w;
        // Write to the in-range mirror word, then access an address beyond DEPTH on dut1.
        do_op(k, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        do_op(k, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op(k, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        do_op(k, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op(k, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        // Same-edge loads with read+write together: treated as a write of the new MDR.
        do_op(k, 32'h1234_5610, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op(k, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        do_op(k, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op(k, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        do_op(k, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op(k, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        do_op(k, 32'hCAFE_00FF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op(k, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        do_op(k, 32'h5A5A_5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op(k, 32'h0000_01FF, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        do_op(k, 32'h0000_01FF, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        do_op(k, 32'h0000_00FF, 1'b1, 1'b0, 1'b1, 1'b0, 2);
        do_op(k, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        // Write 0x020, reset mid-access, then read back the original word.
        do_op(k, 32'hA5A5_0020, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        do_op(k, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        reset_mid(k, 32'h0000_0020, 32'h5555_5555);
        do_op(k, 32'h0000_0020, 1'b1, 1'b0, 1'b1, 1'b0, 0);
`ifdef MEM_PARITY_EN
        if (k == 0) begin
            do_op(k, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 1'b0, 0);
            do_op(k, 32'h0000_0030, 1'b1, 1'b0, 1'b0, 1'b1, 0);
            tick();
            u_dut0.u_array.mem[9'h030][3] = ~u_dut0.u_array.mem[9'h030][3];
            force_perr[k] = 1'b1;
            ref_mem[k][9'h030][3] = ~ref_mem[k][9'h030][3];
            do_op(k, 32'h0000_0030, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        end
`endif
        for (int i = 0; i < 150; i++) begin
            b  = $urandom;
            lm = ($urandom_range(0, 2) != 0);
            ld = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            w  = ($urandom_range(0, 2) == 0);
            do_op(k, b, lm, ld, r, w, int'($urandom_range(0, 2)));
        end
    endtask

    // Monitor: every done pulse pops the oldest expectation and compares.
    exp_t m_e;
    always @(negedge clock) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (done_o[k] === 1'b1) begin
                    if (qsize(k) == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done dut%0d: got done=1, expected no pending access (cycle %0d)", k, cyc);
                    end else begin
                        m_e = qpop(k);
                        chk("latency", k, 32'(cyc), 32'(m_e.due));
                        chk("addr_err", k, 32'(aerr_o[k]), 32'(m_e.aerr));
                        chk("parity_err", k, 32'(perr_o[k]), 32'(m_e.perr));
                        if (m_e.chk_mdr) chk("mdr", k, mdr_o[k], m_e.mdr);
                        $display("[TB] dut%0d %s done cycle %0d mdr=%h addr_err=%0d",
                                 k, m_e.is_write ? "write" : "read", cyc, mdr_o[k], aerr_o[k]);
                    end
                end else if (aerr_o[k] !== 1'b0 || perr_o[k] !== 1'b0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stray_error_pulse dut%0d: got addr_err=%0d parity_err=%0d, expected 0 without done",
                             k, aerr_o[k], perr_o[k]);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            clear_v[k]       = 1'b0;
            drive_idle(k);
            ref_mar[k]       = '0;
            ref_mdr[k]       = '0;
            ref_mdr_known[k] = 1'b1;
            force_perr[k]    = 1'b0;
            for (int a = 0; a < 512; a++) begin
                ref_known[k][a] = 1'b0;
                ref_mem[k][a]   = '0;
            end
        end
        repeat (3) tick();
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            chk("reset_busy", k, 32'(busy_o[k]), 32'd0);
            chk("reset_done", k, 32'(done_o[k]), 32'd0);
            chk("reset_addr_err", k, 32'(aerr_o[k]), 32'd0);
            chk("reset_mdr", k, mdr_o[k], 32'd0);
        end
        mon_en = 1'b1;
        tick();
        clear_v[0] = 1'b1;
        clear_v[1] = 1'b1;
        fork
            drive_seq(0);
            drive_seq(1);
        join
        repeat (8) tick();
        for (int k = 0; k < 2; k++) begin
            chk("drain_pending", k, 32'(qsize(k)), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_interface.md
MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width of bus, MAR-data path, MDR and array.
REQ-002 SHALL have parameter ADDR_W, default 9, MAR width.
REQ-003 SHALL have parameter DEPTH, default 512, array words; legal range 1..2**ADDR_W.
REQ-004 SHALL have parameter WAIT_STATES, default 1, extra access cycles; legal range 0..15.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port clear  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port BusMuxOut  input  DATA_W  bus value for MAR/MDR load.
REQ-008 SHALL have port MARin  input  1  load MAR from BusMuxOut[ADDR_W-1:0].
REQ-009 SHALL have port MDRin  input  1  load MDR from BusMuxOut.
REQ-010 SHALL have port read  input  1  start read of mem[MAR] into MDR.
REQ-011 SHALL have port write  input  1  start write of MDR into mem[MAR].
REQ-012 SHALL have port BusMuxInMDR  output  DATA_W  current MDR contents.
REQ-013 SHALL have port busy  output  1  access in progress.
REQ-014 SHALL have port done  output  1  one-cycle access-complete pulse.
REQ-015 SHALL have port addr_err  output  1  one-cycle pulse, completed access had MAR >= DEPTH.

Function
REQ-016 SHALL implement states IDLE, WAIT, ACCESS; busy=1 exactly in WAIT and ACCESS.
REQ-017 SHALL, in IDLE with read or write sampled high, latch op and go to WAIT (WAIT_STATES>0) or ACCESS (WAIT_STATES=0).
REQ-018 SHALL stay in WAIT exactly WAIT_STATES cycles via a 4-bit down-counter, then enter ACCESS.
REQ-019 SHALL, in ACCESS, perform the op on the array, return to IDLE, and drive done=1 in the next cycle only.
REQ-020 SHALL give request-to-done latency of WAIT_STATES+2 cycles; for reads, BusMuxInMDR holds new data in the done cycle.
REQ-021 SHALL treat read and write sampled together in IDLE as a write.
REQ-022 SHALL ignore read, write, MARin and MDRin while busy=1; MAR and MDR stay stable.
REQ-023 SHALL let MARin and MDRin in IDLE load on the same edge as a request; the request uses the newly loaded values.
REQ-024 SHALL, on out-of-range MAR (>= DEPTH), drop writes, load 0 into MDR for reads, and pulse addr_err with done.
REQ-025 SHALL allow back-to-back requests: a request in the done cycle is accepted.

Reset
REQ-026 SHALL, with clear=0 at a rising edge, force IDLE, MAR=0, MDR=0, counter=0, busy=0, done=0, addr_err=0.
REQ-027 SHALL, on reset mid-operation, abandon the op: no array write, no done pulse.
REQ-028 SHALL NOT clear array contents on reset.

Configuration
REQ-029 SHALL, with MEM_PARITY_EN defined, store one even-parity bit per word, check it on read, and add output parity_err (1 bit) pulsing with done on mismatch; MDR still loads the read data.
REQ-030 SHALL, without MEM_PARITY_EN, omit parity storage, logic and the parity_err port.

Structure
REQ-031 SHALL take the state enum, WAIT_STATES width constant, and default parameter values from a shared package mem_pkg.
REQ-032 SHALL put the storage array in sub-module mem_array: synchronous write and registered read, parametrised by DATA_W (plus parity bit), ADDR_W, DEPTH.

Verification
REQ-033 SHALL test: WAIT_STATES=1, MARin with 0x005, MDRin with 0xDEADBEEF, write; then read -> done at request+3 cycles, BusMuxInMDR=0xDEADBEEF.
REQ-034 SHALL test: WAIT_STATES=0, read+write same cycle at MAR=0x010, MDR=0x12345678 -> treated as write; later read returns 0x12345678.
REQ-035 SHALL test: DEPTH=256, MAR=0x1FF, write then read -> addr_err pulses both times, MDR=0, mem[0xFF] unchanged.
REQ-036 SHALL test: MDRin with 0xFFFFFFFF while busy -> ignored; MDR retains prior value.
REQ-037 SHALL test: clear=0 in WAIT of a write to 0x020 -> busy=0 next cycle, no done, mem[0x020] unchanged.
REQ-038 SHALL test (MEM_PARITY_EN): force a flipped stored bit at 0x030, read -> parity_err=1 with done.
